// File: rtl/calc_cmd_sequencer.sv
// Paces buffered keypad codes into the calculator core: one command per ready window,
// waiting for the core to acknowledge and finish before issuing the next. Latches core errors.
module calc_cmd_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter logic [3:0]  IDLE_CMD    = 4'hD
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic                         key_ready,
    input  logic [1:0]                   calc_status,
    output logic [3:0]                   calc_cmd,
    output logic                         busy,
    output logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    input  logic                         err_clear
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] STAT_ERROR = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_READY = 2'b10;
    localparam logic [1:0] STAT_PRINT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic               full, empty, push, pop, flush;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign key_ready = !full && (state_q != S_ERROR);
    assign push      = key_valid && key_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cmd_d   = IDLE_CMD;
        pop     = 1'b0;
        flush   = 1'b0;
        if (state_q != S_ERROR && calc_status == STAT_ERROR) begin
            state_d = S_ERROR;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty && calc_status == STAT_READY) begin
                        pop     = 1'b1;
                        cmd_d   = mem_q[rd_ptr_q];
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // A core that never leaves READY consumed the command silently (e.g. an operator).
                    if (calc_status == STAT_BUSY || calc_status == STAT_PRINT) begin
                        state_d = S_WAIT_DONE;
                    end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (calc_status == STAT_READY) state_d = S_IDLE;
                end
                S_ERROR: begin
                    if (err_clear) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT_ACK) || (state_d == S_WAIT_DONE);
    assign error_d = (state_d == S_ERROR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            cmd_q    <= IDLE_CMD;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= key_code;
    end

    assign calc_cmd   = cmd_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model of the command pacing rules.
module tb_calc_cmd_sequencer;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned ACK_TIMEOUT = 4;
    localparam logic [3:0]  IDLE_CMD    = 4'hD;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [1:0] calc_status;
    logic [3:0] calc_cmd;
    logic       busy;
    logic       error;
    logic [2:0] fifo_count;
    logic       err_clear;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending keys, and where the current command is in its life.
    logic [3:0] m_q[$];
    bit         m_err;
    bit         m_issue;     // command on calc_cmd this cycle
    int         m_ack;       // cycles spent waiting for the core to react, -1 if not waiting
    bit         m_done;      // core reacted, waiting for it to become ready again
    logic [3:0] m_cmd;

    calc_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .IDLE_CMD    (IDLE_CMD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .calc_status (calc_status),
        .calc_cmd    (calc_cmd),
        .busy        (busy),
        .error       (error),
        .fifo_count  (fifo_count),
        .err_clear   (err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_err   = 1'b0;
        m_issue = 1'b0;
        m_ack   = -1;
        m_done  = 1'b0;
        m_cmd   = IDLE_CMD;
    endfunction

    function automatic bit m_ready();
        return (m_q.size() < DEPTH) && !m_err;
    endfunction

    function automatic bit m_busy();
        return m_issue || (m_ack >= 0) || m_done;
    endfunction

    function automatic void model_edge(input logic kv, input logic [3:0] kc,
                                       input logic [1:0] st, input logic clr);
        bit accepted;
        accepted = kv && m_ready();
        m_cmd    = IDLE_CMD;
        if (!m_err && st == ST_ERR) begin
            m_err    = 1'b1;
            m_issue  = 1'b0;
            m_ack    = -1;
            m_done   = 1'b0;
            m_q.delete();
            accepted = 1'b0;
        end else if (m_err) begin
            if (clr) m_err = 1'b0;
        end else if (m_issue) begin
            m_issue = 1'b0;
            m_ack   = 0;
        end else if (m_ack >= 0) begin
            if (st == ST_BUSY || st == ST_PRINT) begin
                m_ack  = -1;
                m_done = 1'b1;
            end else if (m_ack == ACK_TIMEOUT - 1) begin
                m_ack = -1;
            end else begin
                m_ack++;
            end
        end else if (m_done) begin
            if (st == ST_READY) m_done = 1'b0;
        end else if (m_q.size() > 0 && st == ST_READY) begin
            m_cmd   = m_q.pop_front();
            m_issue = 1'b1;
        end
        if (accepted) m_q.push_back(kc);
    endfunction

    task automatic step(input logic kv, input logic [3:0] kc, input logic [1:0] st, input logic clr);
        @(negedge clock);
        key_valid   = kv;
        key_code    = kc;
        calc_status = st;
        err_clear   = clr;
        #1 check("key_ready", {7'd0, key_ready}, {7'd0, m_ready()});
        @(posedge clock);
        model_edge(kv, kc, st, clr);
        #1;
        check("calc_cmd",   {4'd0, calc_cmd},   {4'd0, m_cmd});
        check("busy",       {7'd0, busy},       {7'd0, m_busy()});
        check("error",      {7'd0, error},      {7'd0, m_err});
        check("fifo_count", {5'd0, fifo_count}, 8'(m_q.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"},   {4'd0, calc_cmd},   {4'd0, IDLE_CMD});
        check({tag, "_busy"},  {7'd0, busy},       8'd0);
        check({tag, "_error"}, {7'd0, error},      8'd0);
        check({tag, "_count"}, {5'd0, fifo_count}, 8'd0);
        check({tag, "_ready"}, {7'd0, key_ready},  8'd1);
    endtask

    initial begin
        logic [3:0] rk;
        logic [1:0] rs;
        int         r;

        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        calc_status = ST_READY;
        err_clear   = 1'b0;
        model_reset();
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // 1: two digits, core acknowledges each with a printing burst
        step(1'b1, 4'h3, ST_READY, 1'b0);
        step(1'b1, 4'h5, ST_READY, 1'b0);
        check("t1_cmd3", {4'd0, calc_cmd}, 8'h03);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 4'h0, ST_PRINT, 1'b0);
        check("t1_busy", {7'd0, busy}, 8'd1);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        check("t1_cmd5", {4'd0, calc_cmd}, 8'h05);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, ST_READY, 1'b0);

        // 2: operator never acknowledged, released by the timeout
        step(1'b1, 4'hA, ST_READY, 1'b0);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        check("t2_cmdA", {4'd0, calc_cmd}, 8'h0A);
        for (int i = 0; i < 1 + ACK_TIMEOUT; i++) step(1'b0, 4'h0, ST_READY, 1'b0);
        check("t2_idle", {7'd0, busy}, 8'd0);
        step(1'b1, 4'h7, ST_READY, 1'b0);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        check("t2_cmd7", {4'd0, calc_cmd}, 8'h07);
        for (int i = 0; i < 6; i++) step(1'b0, 4'h0, ST_READY, 1'b0);

        // 3: fill the FIFO while the core is busy; fifth key must wait for a pop
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), ST_BUSY, 1'b0);
        check("t3_full_count", {5'd0, fifo_count}, 8'd4);
        check("t3_full_ready", {7'd0, key_ready}, 8'd0);
        step(1'b1, 4'h5, ST_BUSY, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h5, ST_READY, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 4'h0, ST_READY, 1'b0);

        // 4: push and pop on the same edge at count 2
        step(1'b1, 4'h1, ST_BUSY, 1'b0);
        step(1'b1, 4'h2, ST_BUSY, 1'b0);
        step(1'b1, 4'h3, ST_READY, 1'b0);
        check("t4_count", {5'd0, fifo_count}, 8'd2);
        for (int i = 0; i < 20; i++) step(1'b0, 4'h0, ST_READY, 1'b0);

        // 5: core error flushes the buffer; err_clear recovers
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 6), ST_BUSY, 1'b0);
        step(1'b0, 4'h0, ST_ERR, 1'b0);
        check("t5_error", {7'd0, error}, 8'd1);
        check("t5_count", {5'd0, fifo_count}, 8'd0);
        check("t5_ready", {7'd0, key_ready}, 8'd0);
        step(1'b1, 4'h4, ST_BUSY, 1'b0);
        step(1'b0, 4'h0, ST_BUSY, 1'b1);
        check("t5_clear", {7'd0, error}, 8'd0);
        step(1'b0, 4'h0, ST_READY, 1'b0);

        // 6: reset while waiting for the core to finish
        step(1'b1, 4'h9, ST_READY, 1'b0);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        step(1'b0, 4'h0, ST_READY, 1'b0);
        step(1'b0, 4'h0, ST_BUSY, 1'b0);
        step(1'b1, 4'h6, ST_BUSY, 1'b0);
        @(negedge clock);
        key_valid = 1'b0;
        reset     = 1'b1;
        #1 check_reset_outputs("t6_rst");
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 4'h0, ST_READY, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            rs = (r < 2) ? ST_ERR : (r < 15) ? ST_BUSY : (r < 30) ? ST_PRINT : ST_READY;
            rk = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), rk, rs, ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
